// File: rtl/calc_arb_pkg.sv
// ----------------------------------------------------------------------------
// calc_arb_pkg : shared encodings and state types for the calculator port arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package calc_arb_pkg;

  localparam logic [0:3] CMD_NOP = 4'd0;
  localparam logic [0:3] CMD_ADD = 4'd1;
  localparam logic [0:3] CMD_SUB = 4'd2;
  localparam logic [0:3] CMD_SHL = 4'd5;
  localparam logic [0:3] CMD_SHR = 4'd6;

  localparam logic [0:1] RESP_NONE = 2'd0;
  localparam logic [0:1] RESP_OK   = 2'd1;
  localparam logic [0:1] RESP_ERR  = 2'd2;
  localparam logic [0:1] RESP_TMO  = 2'd3;

  typedef enum logic [1:0] {
    P_IDLE = 2'd0,
    P_OP2  = 2'd1,
    P_WAIT = 2'd2,
    P_RESP = 2'd3
  } port_state_t;

  typedef enum logic {
    A_IDLE = 1'b0,
    A_BUSY = 1'b1
  } arb_state_t;

  function automatic logic is_valid_cmd(input logic [0:3] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_SHL) || (cmd == CMD_SHR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/calc_port_ctl.sv
// ----------------------------------------------------------------------------
// calc_port_ctl : one request port - command/operand capture FSM and response register
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module calc_port_ctl
  import calc_arb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [0:3]        i_cmd,
  input  logic [0:DATA_W-1] i_data,
  input  logic              i_done,
  input  logic              i_tmo,
  input  logic [0:DATA_W-1] i_result,
  input  logic [0:1]        i_resp,
  output logic              o_wait,
  output logic [0:3]        o_cmd,
  output logic [0:DATA_W-1] o_op1,
  output logic [0:DATA_W-1] o_op2,
  output logic [0:DATA_W-1] o_data,
  output logic [0:1]        o_resp
);

  port_state_t       r_state;
  logic [0:3]        r_cmd;
  logic [0:DATA_W-1] r_op1;
  logic [0:DATA_W-1] r_op2;
  logic [0:DATA_W-1] r_data;
  logic [0:1]        r_resp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= P_IDLE;
      r_cmd   <= CMD_NOP;
      r_op1   <= '0;
      r_op2   <= '0;
      r_data  <= '0;
      r_resp  <= RESP_NONE;
    end else begin
      case (r_state)
        P_IDLE: begin
          if (i_cmd != CMD_NOP) begin
            r_cmd   <= i_cmd;
            r_op1   <= i_data;
            r_state <= P_OP2;
          end
        end
        P_OP2: begin
          r_op2 <= i_data;
          // Unsupported opcodes are answered locally and never compete for the ALU
          if (is_valid_cmd(r_cmd)) begin
            r_state <= P_WAIT;
          end else begin
            r_data  <= '0;
            r_resp  <= RESP_ERR;
            r_state <= P_RESP;
          end
        end
        P_WAIT: begin
          if (i_done) begin
            r_data  <= i_result;
            r_resp  <= i_resp;
            r_state <= P_RESP;
          end else if (i_tmo) begin
            r_data  <= '0;
            r_resp  <= RESP_TMO;
            r_state <= P_RESP;
          end
        end
        P_RESP: begin
          r_data  <= '0;
          r_resp  <= RESP_NONE;
          r_state <= P_IDLE;
        end
        default: r_state <= P_IDLE;
      endcase
    end
  end

  assign o_wait = (r_state == P_WAIT);
  assign o_cmd  = r_cmd;
  assign o_op1  = r_op1;
  assign o_op2  = r_op2;
  assign o_data = r_data;
  assign o_resp = r_resp;

endmodule

`default_nettype wire

// File: rtl/calc_port_arbiter.sv
// ----------------------------------------------------------------------------
// calc_port_arbiter : round-robin sequencing of four calculator ports onto one ALU
// Optional ALU watchdog enabled by defining CALC_ARB_TIMEOUT_EN.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module calc_port_arbiter
  import calc_arb_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic [0:3]        req1_cmd_in,
  input  logic [0:DATA_W-1] req1_data_in,
  input  logic [0:3]        req2_cmd_in,
  input  logic [0:DATA_W-1] req2_data_in,
  input  logic [0:3]        req3_cmd_in,
  input  logic [0:DATA_W-1] req3_data_in,
  input  logic [0:3]        req4_cmd_in,
  input  logic [0:DATA_W-1] req4_data_in,
  output logic [0:DATA_W-1] out_data1,
  output logic [0:1]        out_resp1,
  output logic [0:DATA_W-1] out_data2,
  output logic [0:1]        out_resp2,
  output logic [0:DATA_W-1] out_data3,
  output logic [0:1]        out_resp3,
  output logic [0:DATA_W-1] out_data4,
  output logic [0:1]        out_resp4,
  output logic              alu_valid,
  output logic [0:3]        alu_cmd,
  output logic [0:DATA_W-1] alu_op1,
  output logic [0:DATA_W-1] alu_op2,
  output logic              alu_abort,
  input  logic              alu_done,
  input  logic [0:DATA_W-1] alu_result,
  input  logic [0:1]        alu_resp
);

  if (2**CNT_W <= TIMEOUT_CYCLES) begin : g_cnt_w_check
    $error("CNT_W too narrow to count TIMEOUT_CYCLES");
  end

  logic [0:3]        w_cmd_in  [4];
  logic [0:DATA_W-1] w_data_in [4];
  logic [0:3]        w_cmd     [4];
  logic [0:DATA_W-1] w_op1     [4];
  logic [0:DATA_W-1] w_op2     [4];
  logic [0:DATA_W-1] w_data    [4];
  logic [0:1]        w_resp    [4];
  logic [3:0]        w_wait;
  logic [3:0]        w_done_vec;
  logic [3:0]        w_tmo_vec;

  assign w_cmd_in[0]  = req1_cmd_in;
  assign w_cmd_in[1]  = req2_cmd_in;
  assign w_cmd_in[2]  = req3_cmd_in;
  assign w_cmd_in[3]  = req4_cmd_in;
  assign w_data_in[0] = req1_data_in;
  assign w_data_in[1] = req2_data_in;
  assign w_data_in[2] = req3_data_in;
  assign w_data_in[3] = req4_data_in;

  for (genvar gi = 0; gi < 4; gi++) begin : g_port
    calc_port_ctl #(.DATA_W(DATA_W)) u_port (
      .clk      (c_clk),
      .rst      (reset),
      .i_cmd    (w_cmd_in[gi]),
      .i_data   (w_data_in[gi]),
      .i_done   (w_done_vec[gi]),
      .i_tmo    (w_tmo_vec[gi]),
      .i_result (alu_result),
      .i_resp   (alu_resp),
      .o_wait   (w_wait[gi]),
      .o_cmd    (w_cmd[gi]),
      .o_op1    (w_op1[gi]),
      .o_op2    (w_op2[gi]),
      .o_data   (w_data[gi]),
      .o_resp   (w_resp[gi])
    );
  end

  assign out_data1 = w_data[0];
  assign out_data2 = w_data[1];
  assign out_data3 = w_data[2];
  assign out_data4 = w_data[3];
  assign out_resp1 = w_resp[0];
  assign out_resp2 = w_resp[1];
  assign out_resp3 = w_resp[2];
  assign out_resp4 = w_resp[3];

  arb_state_t r_arb_state;
  logic [1:0] r_ptr;
  logic [1:0] r_owner;
  logic       w_found;
  logic [1:0] w_grant;
  logic       w_issue;
  logic       w_done_hit;
  logic       w_tmo_hit;

  // 2-bit index arithmetic wraps naturally, giving the cyclic 1->2->3->4->1 search
  always_comb begin
    w_found = 1'b0;
    w_grant = r_ptr;
    for (int k = 0; k < 4; k++) begin
      if (!w_found && w_wait[r_ptr + 2'(k)]) begin
        w_found = 1'b1;
        w_grant = r_ptr + 2'(k);
      end
    end
  end

  assign w_issue    = (r_arb_state == A_IDLE) && w_found;
  assign w_done_hit = (r_arb_state == A_BUSY) && alu_done;
  assign w_done_vec = w_done_hit ? (4'b0001 << r_owner) : 4'b0000;
  assign w_tmo_vec  = w_tmo_hit  ? (4'b0001 << r_owner) : 4'b0000;

  assign alu_valid = w_issue;
  assign alu_cmd   = w_issue ? w_cmd[w_grant] : CMD_NOP;
  assign alu_op1   = w_issue ? w_op1[w_grant] : '0;
  assign alu_op2   = w_issue ? w_op2[w_grant] : '0;

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      r_arb_state <= A_IDLE;
      r_ptr       <= 2'd0;
      r_owner     <= 2'd0;
    end else begin
      case (r_arb_state)
        A_IDLE: begin
          if (w_found) begin
            r_arb_state <= A_BUSY;
            r_owner     <= w_grant;
            r_ptr       <= w_grant + 2'd1;
          end
        end
        A_BUSY: begin
          if (w_done_hit || w_tmo_hit) begin
            r_arb_state <= A_IDLE;
          end
        end
        default: r_arb_state <= A_IDLE;
      endcase
    end
  end

`ifdef CALC_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] r_busy_cnt;

  // Counter holds (busy cycle - 1); a coincident alu_done takes priority over the abort
  assign w_tmo_hit = (r_arb_state == A_BUSY) && !alu_done &&
                     (r_busy_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign alu_abort = w_tmo_hit;

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      r_busy_cnt <= '0;
    end else if (w_issue) begin
      r_busy_cnt <= '0;
    end else if (r_arb_state == A_BUSY) begin
      r_busy_cnt <= r_busy_cnt + 1'b1;
    end
  end
`else
  assign w_tmo_hit = 1'b0;
  assign alu_abort = 1'b0;
`endif

endmodule

`default_nettype wire
